// File: rtl/fp_exc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_exc_pkg
// Description : Shared definitions for the FP special-case resolver:
//               exception-class encodings and helpers that build the
//               all-ones exponent and canonical quiet NaN for any
//               EXP_W/MAN_W format.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_exc_pkg;

    // Exception class encodings reported on exc_class
    localparam logic [2:0] EXC_NONE    = 3'd0;
    localparam logic [2:0] EXC_QNAN    = 3'd1;
    localparam logic [2:0] EXC_SNAN    = 3'd2;
    localparam logic [2:0] EXC_INVALID = 3'd3;
    localparam logic [2:0] EXC_INF     = 3'd4;
    localparam logic [2:0] EXC_ZERO    = 3'd5;

    // All-ones exponent, right-aligned in a 64-bit container
    function automatic logic [63:0] exp_all_ones(input int exp_w);
        return (64'd1 << exp_w) - 64'd1;
    endfunction

    // Canonical qNaN {0, all-ones exp, 1, zeros}, right-aligned in 128 bits
    function automatic logic [127:0] canon_qnan(input int exp_w, input int man_w);
        logic [127:0] v;
        v = (128'd1 << (exp_w + man_w)) - (128'd1 << man_w);
        v = v | (128'd1 << (man_w - 1));
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// ============================================================================
// Module      : fp_classify
// Description : Combinational IEEE-754 operand classifier.
//   i_exp     : exponent field
//   i_mant    : stored mantissa field
//   o_isnan   : NaN (quiet or signalling)
//   o_issnan  : signalling NaN (mantissa MSB clear)
//   o_isinf   : infinity
//   o_iszero  : exact zero
//   o_issub   : subnormal (exp=0, mant!=0)
// Revision    : 1.0 - initial release
// ============================================================================
module fp_classify
    import fp_exc_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic [EXP_W-1:0] i_exp,
    input  logic [MAN_W-1:0] i_mant,
    output logic             o_isnan,
    output logic             o_issnan,
    output logic             o_isinf,
    output logic             o_iszero,
    output logic             o_issub
);

    localparam logic [EXP_W-1:0] C_EXP_ONES = EXP_W'(exp_all_ones(EXP_W));

    logic exp_ones;
    logic exp_zero;
    logic mant_zero;

    assign exp_ones  = (i_exp == C_EXP_ONES);
    assign exp_zero  = (i_exp == '0);
    assign mant_zero = (i_mant == '0);

    assign o_isnan   = exp_ones & ~mant_zero;
    assign o_issnan  = exp_ones & ~mant_zero & ~i_mant[MAN_W-1];
    assign o_isinf   = exp_ones & mant_zero;
    assign o_iszero  = exp_zero & mant_zero;
    assign o_issub   = exp_zero & ~mant_zero;

endmodule
`default_nettype wire

// File: rtl/fp_exception_sum_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_exception_sum_pipe
// Description : Two-stage valid/ready pipeline that classifies two FP
//               operands and resolves special-case sums (NaN propagation,
//               Inf-Inf invalid, infinities, zero operands). exc=1 means q
//               is final. Sticky invalid/NaN flags feed the status register.
//   Config    : define FP_EXC_DAZ_EN to treat subnormal inputs as zero.
//   Ports     : clk, rst (async, active high)
//               in_valid/in_ready, sign_/exp_/mant_ a,b, tag_in  - operands
//               out_valid/out_ready, q, exc, exc_class, tag_out  - result
//               flag_clr, flag_invalid, flag_nan                  - sticky flags
// Revision    : 1.0 - initial release
// ============================================================================
module fp_exception_sum_pipe
    import fp_exc_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   sign_a,
    input  logic                   sign_b,
    input  logic [EXP_W-1:0]       exp_a,
    input  logic [EXP_W-1:0]       exp_b,
    input  logic [MAN_W-1:0]       mant_a,
    input  logic [MAN_W-1:0]       mant_b,
    input  logic [TAG_W-1:0]       tag_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   q,
    output logic                   exc,
    output logic [2:0]             exc_class,
    output logic [TAG_W-1:0]       tag_out,
    input  logic                   flag_clr,
    output logic                   flag_invalid,
    output logic                   flag_nan
);

    localparam int                W          = 1 + EXP_W + MAN_W;
    localparam logic [EXP_W-1:0]  C_EXP_ONES = EXP_W'(exp_all_ones(EXP_W));
    localparam logic [MAN_W-1:0]  C_MAN_MSB  = {1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0]      C_QNAN     = W'(canon_qnan(EXP_W, MAN_W));

    // ---------------- operand classification ----------------
    logic nan_a, snan_a, inf_a, zero_a, sub_a;
    logic nan_b, snan_b, inf_b, zero_b, sub_b;
    logic zero_eff_a, zero_eff_b;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .i_exp(exp_a), .i_mant(mant_a),
        .o_isnan(nan_a), .o_issnan(snan_a), .o_isinf(inf_a),
        .o_iszero(zero_a), .o_issub(sub_a)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .i_exp(exp_b), .i_mant(mant_b),
        .o_isnan(nan_b), .o_issnan(snan_b), .o_isinf(inf_b),
        .o_iszero(zero_b), .o_issub(sub_b)
    );

`ifdef FP_EXC_DAZ_EN
    // Subnormals flushed to zero for classification only; the raw operand
    // is still what gets passed through when the other side is zero.
    assign zero_eff_a = zero_a | sub_a;
    assign zero_eff_b = zero_b | sub_b;
`else
    logic unused_sub;
    assign unused_sub = sub_a ^ sub_b;
    assign zero_eff_a = zero_a;
    assign zero_eff_b = zero_b;
`endif

    // ---------------- pipeline state ----------------
    logic                 s1_valid_q, s1_valid_d;
    logic [W-1:0]         op_a_q, op_a_d, op_b_q, op_b_d;
    logic [TAG_W-1:0]     s1_tag_q, s1_tag_d;
    // per operand {nan, snan, inf, zero}
    logic [3:0]           cls_a_q, cls_a_d, cls_b_q, cls_b_d;

    logic                 out_valid_q, out_valid_d;
    logic [W-1:0]         q_q, q_d;
    logic                 exc_q, exc_d;
    logic [2:0]           exc_class_q, exc_class_d;
    logic [TAG_W-1:0]     tag_out_q, tag_out_d;
    logic                 flag_invalid_q, flag_invalid_d;
    logic                 flag_nan_q, flag_nan_d;

    logic                 en;
    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;

    // ---------------- resolution from stage-1 registers ----------------
    logic                 a_nan, a_snan, a_inf, a_zero;
    logic                 b_nan, b_snan, b_inf, b_zero;
    logic [W-1:0]         res_val;
    logic                 res_exc;
    logic [2:0]           res_cls;

    assign {a_nan, a_snan, a_inf, a_zero} = cls_a_q;
    assign {b_nan, b_snan, b_inf, b_zero} = cls_b_q;

    always_comb begin
        res_val = '0;
        res_exc = 1'b1;
        res_cls = EXC_NONE;
        if (a_nan && b_nan) begin
            res_val = {op_a_q[W-1], C_EXP_ONES, op_a_q[MAN_W-1:0] | C_MAN_MSB};
            res_cls = (a_snan || b_snan) ? EXC_SNAN : EXC_QNAN;
        end else if (a_nan) begin
            res_val = op_a_q | W'(C_MAN_MSB);
            res_cls = a_snan ? EXC_SNAN : EXC_QNAN;
        end else if (b_nan) begin
            res_val = op_b_q | W'(C_MAN_MSB);
            res_cls = b_snan ? EXC_SNAN : EXC_QNAN;
        end else if (a_inf && b_inf && (op_a_q[W-1] != op_b_q[W-1])) begin
            res_val = C_QNAN;
            res_cls = EXC_INVALID;
        end else if (a_inf) begin
            // covers same-sign Inf+Inf as well
            res_val = op_a_q;
            res_cls = EXC_INF;
        end else if (b_inf) begin
            res_val = op_b_q;
            res_cls = EXC_INF;
        end else if (a_zero && b_zero) begin
            res_val = {op_a_q[W-1] & op_b_q[W-1], {(W-1){1'b0}}};
            res_cls = EXC_ZERO;
        end else if (a_zero) begin
            res_val = op_b_q;
            res_cls = EXC_ZERO;
        end else if (b_zero) begin
            res_val = op_a_q;
            res_cls = EXC_ZERO;
        end else begin
            res_exc = 1'b0;
        end
    end

    // ---------------- next-state ----------------
    logic set_invalid, set_nan;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        s1_tag_d    = s1_tag_q;
        cls_a_d     = cls_a_q;
        cls_b_d     = cls_b_q;
        out_valid_d = out_valid_q;
        q_d         = q_q;
        exc_d       = exc_q;
        exc_class_d = exc_class_q;
        tag_out_d   = tag_out_q;
        set_invalid = 1'b0;
        set_nan     = 1'b0;

        if (en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                op_a_d   = {sign_a, exp_a, mant_a};
                op_b_d   = {sign_b, exp_b, mant_b};
                s1_tag_d = tag_in;
                cls_a_d  = {nan_a, snan_a, inf_a, zero_eff_a};
                cls_b_d  = {nan_b, snan_b, inf_b, zero_eff_b};
            end

            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                q_d         = res_val;
                exc_d       = res_exc;
                exc_class_d = res_cls;
                tag_out_d   = s1_tag_q;
                set_invalid = (res_cls == EXC_SNAN) || (res_cls == EXC_INVALID);
                set_nan     = (res_cls == EXC_QNAN) || (res_cls == EXC_SNAN) ||
                              (res_cls == EXC_INVALID);
            end else begin
                q_d         = '0;
                exc_d       = 1'b0;
                exc_class_d = EXC_NONE;
                tag_out_d   = '0;
            end
        end

        // A set in the same cycle as a clear takes precedence
        flag_invalid_d = (flag_clr ? 1'b0 : flag_invalid_q) | set_invalid;
        flag_nan_d     = (flag_clr ? 1'b0 : flag_nan_q)     | set_nan;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            s1_tag_q       <= '0;
            cls_a_q        <= '0;
            cls_b_q        <= '0;
            out_valid_q    <= 1'b0;
            q_q            <= '0;
            exc_q          <= 1'b0;
            exc_class_q    <= EXC_NONE;
            tag_out_q      <= '0;
            flag_invalid_q <= 1'b0;
            flag_nan_q     <= 1'b0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            s1_tag_q       <= s1_tag_d;
            cls_a_q        <= cls_a_d;
            cls_b_q        <= cls_b_d;
            out_valid_q    <= out_valid_d;
            q_q            <= q_d;
            exc_q          <= exc_d;
            exc_class_q    <= exc_class_d;
            tag_out_q      <= tag_out_d;
            flag_invalid_q <= flag_invalid_d;
            flag_nan_q     <= flag_nan_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign q            = q_q;
    assign exc          = exc_q;
    assign exc_class    = exc_class_q;
    assign tag_out      = tag_out_q;
    assign flag_invalid = flag_invalid_q;
    assign flag_nan     = flag_nan_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_exception_sum_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_exception_sum_pipe
// Description : Self-checking bench for fp_exception_sum_pipe (half
//               precision). Directed test-plan vectors plus randomized
//               operands/backpressure against a scoreboard fed by a
//               behavioural model. Define FP_EXC_DAZ_EN to match the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_exception_sum_pipe;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int TAG_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic        sign_a, sign_b;
    logic [4:0]  exp_a, exp_b;
    logic [9:0]  mant_a, mant_b;
    logic [3:0]  tag_in;
    logic        out_valid, out_ready;
    logic [15:0] q;
    logic        exc;
    logic [2:0]  exc_class;
    logic [3:0]  tag_out;
    logic        flag_clr, flag_invalid, flag_nan;

    always #5 clk = ~clk;

    fp_exception_sum_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign_a(sign_a), .sign_b(sign_b),
        .exp_a(exp_a), .exp_b(exp_b),
        .mant_a(mant_a), .mant_b(mant_b),
        .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .exc(exc), .exc_class(exc_class), .tag_out(tag_out),
        .flag_clr(flag_clr), .flag_invalid(flag_invalid), .flag_nan(flag_nan)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, expv);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // kind: 0 finite, 1 zero, 2 inf, 3 qNaN, 4 sNaN
    function automatic int kind(input logic [15:0] x);
        int e;
        int m;
        e = int'(x[14:10]);
        m = int'(x[9:0]);
        if (e == 31) return (m == 0) ? 2 : ((m >= 512) ? 3 : 4);
        if (e == 0 && m == 0) return 1;
`ifdef FP_EXC_DAZ_EN
        if (e == 0) return 1;
`endif
        return 0;
    endfunction

    // returns {exc, class[2:0], q[15:0]}
    function automatic logic [19:0] ref_res(input logic [15:0] a, input logic [15:0] b);
        int ka, kb;
        logic [15:0] qa, qb;
        ka = kind(a);
        kb = kind(b);
        qa = a | 16'h0200;
        qb = b | 16'h0200;
        if (ka >= 3 && kb >= 3) return {1'b1, (ka == 4 || kb == 4) ? 3'd2 : 3'd1, qa};
        if (ka >= 3)            return {1'b1, (ka == 4) ? 3'd2 : 3'd1, qa};
        if (kb >= 3)            return {1'b1, (kb == 4) ? 3'd2 : 3'd1, qb};
        if (ka == 2 && kb == 2) return (a[15] != b[15]) ? {1'b1, 3'd3, 16'h7E00} : {1'b1, 3'd4, a};
        if (ka == 2)            return {1'b1, 3'd4, a};
        if (kb == 2)            return {1'b1, 3'd4, b};
        if (ka == 1 && kb == 1) return {1'b1, 3'd5, a[15] & b[15], 15'd0};
        if (ka == 1)            return {1'b1, 3'd5, b};
        if (kb == 1)            return {1'b1, 3'd5, a};
        return 20'd0;
    endfunction

    function automatic logic [15:0] rand_op();
        logic       s;
        logic [9:0] m;
        logic [4:0] e;
        int         k;
        s = 1'($urandom_range(0, 1));
        m = 10'($urandom);
        e = 5'($urandom_range(1, 30));
        k = int'($urandom_range(0, 6));
        case (k)
            0: return {s, 5'h1F, 1'b1, m[8:0]};
            1: return {s, 5'h1F, 1'b0, (m[8:0] == 9'd0) ? 9'd1 : m[8:0]};
            2: return {s, 5'h1F, 10'd0};
            3: return {s, 15'd0};
            4: return {s, 5'd0, (m == 10'd0) ? 10'd1 : m};
            default: return {s, e, m};
        endcase
    endfunction

    // scoreboard entries: {tag, exc, class, q}
    logic [23:0] sb[$];
    logic        head_seen = 1'b0;
    logic        m_inv = 1'b0;
    logic        m_nan = 1'b0;

    // One clock cycle: drive, sample mid-cycle, advance past posedge.
    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] t, input logic rdy, input logic clr,
                         output logic acc);
        logic        hs;
        logic [23:0] h;
        logic [19:0] r;
        in_valid = v;
        {sign_a, exp_a, mant_a} = a;
        {sign_b, exp_b, mant_b} = b;
        tag_in    = t;
        out_ready = rdy;
        flag_clr  = clr;
        #3;
        check("in_ready", {31'd0, in_ready}, {31'd0, ~out_valid | rdy});
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
                h = sb[0];
                check("q",     {16'd0, q},         {16'd0, h[15:0]});
                check("class", {29'd0, exc_class}, {29'd0, h[18:16]});
                check("exc",   {31'd0, exc},       {31'd0, h[19]});
                check("tag",   {28'd0, tag_out},   {28'd0, h[23:20]});
                if (!head_seen) begin
                    head_seen = 1'b1;
                    if (h[18:16] == 3'd2 || h[18:16] == 3'd3) m_inv = 1'b1;
                    if (h[18:16] >= 3'd1 && h[18:16] <= 3'd3) m_nan = 1'b1;
                end
            end
        end
        check("flag_invalid", {31'd0, flag_invalid}, {31'd0, m_inv});
        check("flag_nan",     {31'd0, flag_nan},     {31'd0, m_nan});
        acc = v & in_ready;
        hs  = out_valid & rdy;
        @(posedge clk);
        #1;
        if (clr) begin
            m_inv = 1'b0;
            m_nan = 1'b0;
        end
        if (hs && sb.size() != 0) begin
            void'(sb.pop_front());
            head_seen = 1'b0;
        end
        if (acc) begin
            r = ref_res(a, b);
            sb.push_back({t, r});
        end
    endtask

    task automatic idle(input logic clr);
        logic acc;
        cycle(1'b0, 16'd0, 16'd0, 4'd0, 1'b1, clr, acc);
    endtask

    // directed test-plan table: a, b, expected q, expected class
    localparam int NDIR = 9;
    logic [15:0] d_a [NDIR] = '{16'h7E00, 16'h7C01, 16'h7C00, 16'h7C00, 16'h8000,
                                16'h8000, 16'h0000, 16'h3C00, 16'h0001};
    logic [15:0] d_b [NDIR] = '{16'h3C00, 16'h7E05, 16'hFC00, 16'h7C00, 16'h8000,
                                16'h0000, 16'h4500, 16'h4000, 16'h3C00};
`ifdef FP_EXC_DAZ_EN
    logic [15:0] d_q [NDIR] = '{16'h7E00, 16'h7E01, 16'h7E00, 16'h7C00, 16'h8000,
                                16'h0000, 16'h4500, 16'h0000, 16'h3C00};
    logic [2:0]  d_c [NDIR] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd5, 3'd0, 3'd5};
`else
    logic [15:0] d_q [NDIR] = '{16'h7E00, 16'h7E01, 16'h7E00, 16'h7C00, 16'h8000,
                                16'h0000, 16'h4500, 16'h0000, 16'h0000};
    logic [2:0]  d_c [NDIR] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd5, 3'd0, 3'd0};
`endif

    initial begin
        logic        acc;
        logic [15:0] ops_a [4];
        logic [15:0] ops_b [4];
        int          idx;
        int          cyc;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; flag_clr = 1'b0;
        {sign_a, exp_a, mant_a} = 16'd0;
        {sign_b, exp_b, mant_b} = 16'd0;
        tag_in = 4'd0;
        #12;
        check("rst_out_valid", {31'd0, out_valid},    32'd0);
        check("rst_q",         {16'd0, q},            32'd0);
        check("rst_exc",       {31'd0, exc},          32'd0);
        check("rst_class",     {29'd0, exc_class},    32'd0);
        check("rst_tag",       {28'd0, tag_out},      32'd0);
        check("rst_flags",     {30'd0, flag_invalid, flag_nan}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ---- directed vectors with latency check ----
        for (int i = 0; i < NDIR; i++) begin
            cycle(1'b1, d_a[i], d_b[i], 4'(i), 1'b1, 1'b0, acc);
            check("lat_stage1", {31'd0, out_valid}, 32'd0);
            idle(1'b0);
            check("lat_stage2", {31'd0, out_valid}, 32'd1);
            check("tp_q",     {16'd0, q},         {16'd0, d_q[i]});
            check("tp_class", {29'd0, exc_class}, {29'd0, d_c[i]});
            check("tp_exc",   {31'd0, exc},       {31'd0, d_c[i] != 3'd0});
            idle(1'b0);
        end

        // ---- flag_clr clears both flags ----
        idle(1'b1);
        check("clr_flags", {30'd0, flag_invalid, flag_nan}, 32'd0);

        // ---- set wins over clear in the same cycle ----
        cycle(1'b1, 16'h7C01, 16'h3C00, 4'd9, 1'b1, 1'b0, acc);
        idle(1'b1);
        check("set_wins_inv", {31'd0, flag_invalid}, 32'd1);
        check("set_wins_nan", {31'd0, flag_nan},     32'd1);
        idle(1'b0);
        idle(1'b1);

        // ---- stall: 4 ops, tags 1-4, out_ready low 3 cycles ----
        ops_a = '{16'h7E00, 16'h7C00, 16'h0000, 16'h3C00};
        ops_b = '{16'h3C00, 16'hFC00, 16'h4500, 16'h4000};
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 50) begin
            cycle(1'b1, ops_a[idx], ops_b[idx], 4'(idx + 1),
                  (cyc >= 2 && cyc < 5) ? 1'b0 : 1'b1, 1'b0, acc);
            if (acc) idx++;
            cyc++;
        end
        check("stall_accept_all", idx, 4);
        for (int i = 0; i < 6; i++) idle(1'b0);
        check("stall_drain", sb.size(), 0);

        // ---- randomized traffic with backpressure ----
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_op(), rand_op(), 4'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), acc);
        end
        for (int i = 0; i < 6; i++) idle(1'b0);
        check("rand_drain", sb.size(), 0);

        // ---- asynchronous reset mid-stream ----
        cycle(1'b1, 16'h7E00, 16'h0000, 4'd1, 1'b0, 1'b0, acc);
        cycle(1'b1, 16'h7C01, 16'h0000, 4'd2, 1'b0, 1'b0, acc);
        cycle(1'b1, 16'h7C00, 16'h0000, 4'd3, 1'b0, 1'b0, acc);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_q",     {16'd0, q},         32'd0);
        check("midrst_flags", {30'd0, flag_invalid, flag_nan}, 32'd0);
        sb.delete();
        head_seen = 1'b0;
        m_inv = 1'b0;
        m_nan = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) idle(1'b0);
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_exception_sum_pipe.md
Name: fp_exception_sum_pipe

Overview:
- Parametrised, pipelined successor to the half-precision adder special-case detector.
- Classifies two IEEE-754 operands (NaN, Inf, zero, subnormal, normal) and resolves special-case sums per IEEE rules (quiet-NaN propagation, Inf−Inf invalid, signed-zero rule).
- Sits in front of the FP add datapath. exc=1 means q is final and the datapath result must be discarded.
- Two-stage valid/ready pipeline with sticky invalid/NaN flags for the FP status register.

Parameters:
EXP_W, 5, exponent width (5 = half, 8 = single)
MAN_W, 10, stored mantissa width (10 = half, 23 = single)
TAG_W, 4, width of opaque tag carried alongside each operation

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
sign_a  in  1  sign of A
sign_b  in  1  sign of B
exp_a  in  EXP_W  exponent of A
exp_b  in  EXP_W  exponent of B
mant_a  in  MAN_W  mantissa of A
mant_b  in  MAN_W  mantissa of B
tag_in  in  TAG_W  opaque tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
q  out  1+EXP_W+MAN_W  resolved result {sign, exp, mant}; zero when exc=0
exc  out  1  special case resolved; q is final
exc_class  out  3  0 none, 1 qNaN-in, 2 sNaN-in, 3 inf-inf invalid, 4 inf, 5 zero-operand
tag_out  out  TAG_W  tag of the result
flag_clr  in  1  synchronous clear of sticky flags
flag_invalid  out  1  sticky: sNaN input or Inf−Inf seen
flag_nan  out  1  sticky: any NaN output produced

Behaviour:
- Reset (async, rst=1): both stage valids=0, out_valid=0, q=0, exc=0, exc_class=0, tag_out=0, flag_invalid=0, flag_nan=0. Reset mid-operation discards in-flight data.
- Pipeline enable: en = !out_valid | out_ready. in_ready = en, combinational.
- Transfer on in_valid & in_ready.
- Stage 1 registers the operands plus per-operand class bits:
  - isnan: exp all-ones & mant≠0
  - issnan: isnan & mant MSB=0
  - isinf: exp all-ones & mant=0
  - iszero: exp=0 & mant=0
- Stage 2 registers q/exc/exc_class/tag.
- Latency: exactly 2 cycles from accept to out_valid with no backpressure. Throughput: 1 per cycle.
- When en=0, both stages hold and the outputs stay stable.
- Resolution priority, first match wins:
  1. Both NaN: sign_a, all-ones exp, mant_a with MSB forced to 1. Class 2 if either is sNaN, else 1.
  2. A NaN: A, quieted (mant MSB=1). Class 2 if A is sNaN, else 1.
  3. B NaN: B, quieted. Class 2 if B is sNaN, else 1.
  4. Both Inf with opposite signs: canonical qNaN {0, all-ones, 1 followed by zeros}. Class 3.
  5. Both Inf with same sign: that Inf. Class 4.
  6. A Inf: A. Class 4.
  7. B Inf: B. Class 4.
  8. Both zero: sign = sign_a & sign_b, exp=0, mant=0. Class 5.
  9. A zero: B. Class 5.
  10. B zero: A. Class 5.
  11. Otherwise: exc=0, q=0, class 0.
- Sticky flags update when a result enters stage 2:
  - flag_invalid |= (class 2 or 3)
  - flag_nan |= (class 1, 2 or 3)
- flag_clr in the same cycle as a set: the set wins, so the flag ends at 1.

Optional Feature:
- Macro FP_EXC_DAZ_EN.
- Defined: subnormal inputs (exp=0, mant≠0) are treated as zero of the same sign before classification. When the other operand is passed through in cases 9/10 or is the surviving operand, the output is that operand; when both operands are zero/DAZ, q = ±0.
- Undefined: subnormals classify as normal, giving exc=0.

Decomposition:
- Package fp_exc_pkg holds:
  - exc_class localparams (EXC_NONE, EXC_QNAN, EXC_SNAN, EXC_INVALID, EXC_INF, EXC_ZERO)
  - functions for canonical qNaN and all-ones exponent built from EXP_W/MAN_W
- Sub-module fp_classify (combinational, parametrised, one instance per operand) produces isnan/issnan/isinf/iszero/issub.

Test Plan (half precision):
1. A=0x7E00 (qNaN), B=0x3C00 -> after 2 cycles: q=0x7E00, exc=1, class=1, flag_nan=1, flag_invalid=0.
2. A=0x7C01 (sNaN), B=0x7E05 -> q=0x7E01, class=2, flag_invalid=1.
3. A=0x7C00, B=0xFC00 -> q=0x7E00, class=3. A=0x7C00, B=0x7C00 -> q=0x7C00, class=4.
4. A=0x8000, B=0x8000 -> q=0x8000. A=0x8000, B=0x0000 -> q=0x0000. A=0x0000, B=0x4500 -> q=0x4500. All class 5.
5. A=0x3C00, B=0x4000 -> exc=0, q=0. A=0x0001, B=0x3C00 -> exc=0 without DAZ; q=0x3C00, class=5 with FP_EXC_DAZ_EN.
6. Stream 4 ops with out_ready low for 3 cycles, tags 1-4 -> outputs held stable, in_ready=0 while stalled, tags emerge in order with no loss or duplication. Assert rst mid-stream -> out_valid=0 immediately; flag_clr clears both flags.
